// File: rtl/somador_sinal_acc_if.sv
// Stream bundle for somador_sinal_acc: operands/controls in, result/status out.
// The master modport is the producer/consumer side; the slave modport is the adder itself.
interface somador_sinal_acc_if #(
  parameter int W  = 8,
  parameter int W2 = 4
);
  logic [W-1:0]  entrada_a;
  logic [W2-1:0] entrada_b;
  logic          sinal_a;
  logic          sinal_b;
  logic          op;
  logic          limpa;
  logic          valid_in;
  logic          ready_in;
  logic [W-1:0]  saida;
  logic          estouro;
  logic          valid_out;
  logic          ready_out;
  logic [7:0]    n_estouros;

  modport master (
    output entrada_a, entrada_b, sinal_a, sinal_b, op, limpa, valid_in, ready_out,
    input  ready_in, saida, estouro, valid_out, n_estouros
  );

  modport slave (
    input  entrada_a, entrada_b, sinal_a, sinal_b, op, limpa, valid_in, ready_out,
    output ready_in, saida, estouro, valid_out, n_estouros
  );
endinterface

// File: rtl/somador_sinal_acc.sv
// Signed/unsigned adder-accumulator with optional saturation, overflow flag and
// saturating overflow counter behind a single registered valid/ready stage.
module somador_sinal_acc #(
  parameter int W      = 8,
  parameter int W2     = 4,
  parameter bit SATURA = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  somador_sinal_acc_if.slave bus
);
  localparam int WE = W + 2;

  logic [W-1:0]  saida_q, saida_d;
  logic          estouro_q, estouro_d;
  logic          valid_out_q, valid_out_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          accept;
  logic [W-1:0]  accEff;
  logic [W-1:0]  opX;
  logic [WE-1:0] xExt;
  logic [WE-1:0] bExt;
  logic [WE-1:0] soma;
  logic          resSigned;
  logic          ovf;
  logic [W-1:0]  bound;
  logic [W-1:0]  res;

  assign bus.ready_in   = !valid_out_q || bus.ready_out;
  assign accept         = bus.valid_in && bus.ready_in;
  assign bus.saida      = saida_q;
  assign bus.estouro    = estouro_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.n_estouros = cnt_q;

  // Two guard bits make the exact sum of any W-bit and W2-bit operand pair representable.
  assign accEff    = bus.limpa ? '0 : acc_q;
  assign opX       = bus.op ? accEff : bus.entrada_a;
  assign xExt      = {{2{bus.sinal_a & opX[W-1]}}, opX};
  assign bExt      = {{(WE-W2){bus.sinal_b & bus.entrada_b[W2-1]}}, bus.entrada_b};
  assign soma      = xExt + bExt;
  assign resSigned = bus.sinal_a || bus.sinal_b;

  // Signed fits when the three top bits agree; unsigned fits when both guard bits are clear.
  always_comb begin
    ovf   = 1'b0;
    bound = '0;
    if (resSigned) begin
      ovf   = !((&soma[WE-1:W-1]) || (~|soma[WE-1:W-1]));
      bound = soma[WE-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      ovf   = |soma[WE-1:W];
      bound = soma[WE-1] ? '0 : '1;
    end
    res = (ovf && SATURA) ? bound : soma[W-1:0];
  end

  always_comb begin
    saida_d     = saida_q;
    estouro_d   = estouro_q;
    valid_out_d = valid_out_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      saida_d     = res;
      estouro_d   = ovf;
      valid_out_d = 1'b1;
      acc_d       = res;
      if (ovf && cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      if (valid_out_q && bus.ready_out) begin
        valid_out_d = 1'b0;
      end
      if (bus.limpa) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_q     <= '0;
      estouro_q   <= 1'b0;
      valid_out_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      saida_q     <= saida_d;
      estouro_q   <= estouro_d;
      valid_out_q <= valid_out_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_somador_sinal_acc.sv
// Bench for somador_sinal_acc: a saturating and a wrapping instance driven in lockstep
// with directed vectors, accumulate/backpressure, counter saturation and reset sequences.
module tb_somador_sinal_acc;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  somador_sinal_acc_if #(.W(8), .W2(4)) ifSat ();
  somador_sinal_acc_if #(.W(8), .W2(4)) ifWrap ();

  somador_sinal_acc #(.W(8), .W2(4), .SATURA(1'b1)) dutSat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifSat.slave)
  );

  somador_sinal_acc #(.W(8), .W2(4), .SATURA(1'b0)) dutWrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifWrap.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic       sa;
    logic       sb;
    logic [7:0] expSat;
    logic [7:0] expWrap;
    logic       expOvf;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setInputs(input logic [7:0] a, input logic [3:0] b, input logic sa, input logic sb,
                           input logic op, input logic limpa, input logic vin, input logic rdy);
    ifSat.entrada_a  = a;    ifWrap.entrada_a  = a;
    ifSat.entrada_b  = b;    ifWrap.entrada_b  = b;
    ifSat.sinal_a    = sa;   ifWrap.sinal_a    = sa;
    ifSat.sinal_b    = sb;   ifWrap.sinal_b    = sb;
    ifSat.op         = op;   ifWrap.op         = op;
    ifSat.limpa      = limpa; ifWrap.limpa     = limpa;
    ifSat.valid_in   = vin;  ifWrap.valid_in   = vin;
    ifSat.ready_out  = rdy;  ifWrap.ready_out  = rdy;
  endtask

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b, input logic sa, input logic sb,
                               input logic op, input logic limpa, input logic vin, input logic rdy);
    setInputs(a, b, sa, sb, op, limpa, vin, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int expCnt;
    checks = 0;
    errors = 0;
    expCnt = 0;

    vecs[0]  = '{8'h9C, 4'h8, 1'b1, 1'b1, 8'h94, 8'h94, 1'b0};
    vecs[1]  = '{8'h7F, 4'h7, 1'b1, 1'b1, 8'h7F, 8'h86, 1'b1};
    vecs[2]  = '{8'hFA, 4'hF, 1'b0, 1'b0, 8'hFF, 8'h09, 1'b1};
    vecs[3]  = '{8'hC8, 4'hF, 1'b0, 1'b1, 8'h7F, 8'hC7, 1'b1};
    vecs[4]  = '{8'h80, 4'h8, 1'b1, 1'b1, 8'h80, 8'h78, 1'b1};
    vecs[5]  = '{8'h10, 4'h3, 1'b0, 1'b0, 8'h13, 8'h13, 1'b0};
    vecs[6]  = '{8'h80, 4'hF, 1'b1, 1'b0, 8'h8F, 8'h8F, 1'b0};
    vecs[7]  = '{8'h00, 4'hF, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0};
    vecs[8]  = '{8'hF0, 4'hF, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0};
    vecs[9]  = '{8'hFF, 4'h1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{8'h7F, 4'h0, 1'b1, 1'b1, 8'h7F, 8'h7F, 1'b0};
    vecs[11] = '{8'h05, 4'h8, 1'b0, 1'b1, 8'hFD, 8'hFD, 1'b0};

    rst_n = 1'b0;
    setInputs(8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset saida", {24'h0, ifSat.saida}, 32'h0);
    checkOutput("reset valid_out", {31'h0, ifSat.valid_out}, 32'h0);
    checkOutput("reset ready_in", {31'h0, ifSat.ready_in}, 32'h1);
    checkOutput("reset n_estouros", {24'h0, ifSat.n_estouros}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, 1'b0, 1'b0, 1'b1, 1'b1);
      if (vecs[i].expOvf) expCnt++;
      checkOutput($sformatf("vec%0d saida sat", i), {24'h0, ifSat.saida}, {24'h0, vecs[i].expSat});
      checkOutput($sformatf("vec%0d saida wrap", i), {24'h0, ifWrap.saida}, {24'h0, vecs[i].expWrap});
      checkOutput($sformatf("vec%0d estouro", i), {31'h0, ifSat.estouro}, {31'h0, vecs[i].expOvf});
      checkOutput($sformatf("vec%0d valid_out", i), {31'h0, ifSat.valid_out}, 32'h1);
    end
    checkOutput("vec n_estouros sat", {24'h0, ifSat.n_estouros}, expCnt);
    checkOutput("vec n_estouros wrap", {24'h0, ifWrap.n_estouros}, expCnt);

    // Accumulate 5 per step with a two-cycle stall after the first result.
    applyStimulus(8'h00, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("acc step1", {24'h0, ifSat.saida}, 32'd5);
    setInputs(8'h00, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("stall ready_in", {31'h0, ifSat.ready_in}, 32'h0);
    for (int s = 0; s < 2; s++) begin
      applyStimulus(8'h00, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("stall%0d saida", s), {24'h0, ifSat.saida}, 32'd5);
      checkOutput($sformatf("stall%0d valid_out", s), {31'h0, ifSat.valid_out}, 32'h1);
    end
    for (int s = 2; s <= 4; s++) begin
      applyStimulus(8'h00, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("acc step%0d", s), {24'h0, ifSat.saida}, 5 * s);
      checkOutput($sformatf("acc step%0d wrap", s), {24'h0, ifWrap.saida}, 5 * s);
    end
    applyStimulus(8'h00, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("drain valid_out", {31'h0, ifSat.valid_out}, 32'h0);
    checkOutput("drain saida held", {24'h0, ifSat.saida}, 32'd20);

    // Overflow counter must stop at 255.
    for (int n = 0; n < 250; n++) applyStimulus(8'h7F, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("cnt 254", {24'h0, ifSat.n_estouros}, expCnt + 250);
    applyStimulus(8'h7F, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("cnt 255", {24'h0, ifSat.n_estouros}, 32'd255);
    for (int n = 0; n < 49; n++) applyStimulus(8'h7F, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("cnt sticks sat", {24'h0, ifSat.n_estouros}, 32'd255);
    checkOutput("cnt sticks wrap", {24'h0, ifWrap.n_estouros}, 32'd255);

    // Reset while the output is stalled with an overflowing result pending.
    applyStimulus(8'h7F, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre-reset estouro", {31'h0, ifSat.estouro}, 32'h1);
    checkOutput("pre-reset ready_in", {31'h0, ifSat.ready_in}, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset saida", {24'h0, ifSat.saida}, 32'h0);
    checkOutput("mid reset estouro", {31'h0, ifSat.estouro}, 32'h0);
    checkOutput("mid reset valid_out", {31'h0, ifSat.valid_out}, 32'h0);
    checkOutput("mid reset n_estouros", {24'h0, ifSat.n_estouros}, 32'h0);
    checkOutput("mid reset ready_in", {31'h0, ifSat.ready_in}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h00, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("post-reset acc", {24'h0, ifSat.saida}, 32'd3);
    checkOutput("post-reset valid_out", {31'h0, ifSat.valid_out}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
